temp_fb_render: RTL

TEMP_FB_RENDER -- requirements
Module: temp_fb_render

---
 rtl/temp_fb_pkg.sv | 52 +++++
 rtl/temp_fb_render_font_5x7.sv | 46 ++++
 rtl/temp_fb_render.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/temp_fb_pkg.sv
// Shared layout constants, glyph codes, colours and helpers for the
// temperature framebuffer renderer.
package temp_fb_pkg;

  localparam int unsigned CELL_PITCH = 12;
  localparam int unsigned CELL_W     = 10;
  localparam int unsigned CELL_H     = 14;
  localparam int unsigned CELL_N     = 4;

  localparam logic [10:0] FRAME_LAST = 11'd2047;
  localparam logic [2:0]  DD_LAST    = 3'd7;

  localparam logic [3:0] GLYPH_C     = 4'hA;
  localparam logic [3:0] GLYPH_F     = 4'hB;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;

  localparam logic [11:0] DEF_FG_UP = 12'hF00;
  localparam logic [11:0] DEF_FG_LO = 12'h00F;
  localparam logic [11:0] DEF_BG    = 12'h000;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    RASTER,
    FLUSH,
    DONE
  } state_e;

  // One double-dabble iteration: add 3 to any digit >= 5, then shift in a bit.
  function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic in_bit);
    logic [11:0] adj;
    adj = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj[10:0], in_bit};
  endfunction

  // Glyph for cell k: hundreds, tens, ones (leading zeros blanked), suffix.
  function automatic logic [3:0] cell_glyph(input logic [11:0] bcd, input int unsigned k,
                                            input logic [3:0] suffix);
    logic [3:0] g;
    unique case (k)
      0:       g = (bcd[11:8] == 4'd0) ? GLYPH_BLANK : bcd[11:8];
      1:       g = (bcd[11:4] == 8'd0) ? GLYPH_BLANK : bcd[7:4];
      2:       g = bcd[3:0];
      default: g = suffix;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/temp_fb_render_font_5x7.sv
// Synchronous 5x7 font ROM; bit 4 of the output is the leftmost glyph column.
module font_5x7
  import temp_fb_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] code,
  input  logic [2:0] row,
  output logic [4:0] bits
);

  logic [34:0] glyph;
  logic [5:0]  sel;
  logic [4:0]  bits_d, bits_q;

  always_comb begin
    glyph = '0;
    case (code)
      4'h0:    glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'h1:    glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'h2:    glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'h3:    glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'h4:    glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'h5:    glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'h6:    glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'h7:    glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'h8:    glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'h9:    glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      GLYPH_C: glyph = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      GLYPH_F: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      default: glyph = '0;
    endcase
  end

  always_comb begin
    sel    = 6'(3'd6 - row) * 6'd5;
    bits_d = '0;
    if (row <= 3'd6) bits_d = glyph[sel +: 5];
  end

  always_ff @(posedge clk) begin
    bits_q <= bits_d;
  end

  assign bits = bits_q;

endmodule

// File: rtl/temp_fb_render.sv
// Renders two 3-digit temperatures (C upper half, F lower half) into a
// 2048-word framebuffer: capture, double-dabble, then a 2-stage raster pipe.
module temp_fb_render
  import temp_fb_pkg::*;
#(
  parameter int unsigned X0    = 8,
  parameter int unsigned Y0    = 9,
  parameter logic [11:0] FG_UP = DEF_FG_UP,
  parameter logic [11:0] FG_LO = DEF_FG_LO,
  parameter logic [11:0] BG    = DEF_BG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  temp_c,
  input  logic [7:0]  temp_f,
  input  logic        update,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic        frame_done
);

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  bin_c_q, bin_c_d, bin_f_q, bin_f_d;
  logic [11:0] bcd_c_q, bcd_c_d, bcd_f_q, bcd_f_d;
  logic [2:0]  step_q, step_d;
  logic [10:0] pix_q, pix_d;
  logic        flush_q, flush_d;
  logic        capture;

  logic        s1_valid_q, s1_valid_d;
  logic [10:0] s1_addr_q, s1_addr_d;
  logic        s1_inside_q, s1_inside_d;
  logic [2:0]  s1_gx_q, s1_gx_d;

  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [23:0] wr_data_q, wr_data_d;

  logic        cell_inside;
  logic [2:0]  cell_gx;
  logic [2:0]  glyph_row;
  logic [3:0]  code_up, code_lo;
  logic [4:0]  font_up, font_lo;

  // Control FSM, capture registers and double-dabble
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    bin_c_d   = bin_c_q;
    bin_f_d   = bin_f_q;
    bcd_c_d   = bcd_c_q;
    bcd_f_d   = bcd_f_q;
    step_d    = step_q;
    pix_d     = pix_q;
    flush_d   = flush_q;
    capture   = 1'b0;

    if (update && (state_q != IDLE)) pending_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (update) begin
          capture = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_c_d = dd_step(bcd_c_q, bin_c_q[7]);
        bcd_f_d = dd_step(bcd_f_q, bin_f_q[7]);
        bin_c_d = {bin_c_q[6:0], 1'b0};
        bin_f_d = {bin_f_q[6:0], 1'b0};
        step_d  = step_q + 3'd1;
        if (step_q == DD_LAST) begin
          pix_d   = '0;
          state_d = RASTER;
        end
      end
      RASTER: begin
        pix_d = pix_q + 11'd1;
        if (pix_q == FRAME_LAST) begin
          flush_d = 1'b0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Two cycles let the last address drain through both pipe stages.
        flush_d = 1'b1;
        if (flush_q) state_d = DONE;
      end
      DONE: begin
        pending_d = 1'b0;
        if (pending_q || update) begin
          capture = 1'b1;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      bin_c_d = temp_c;
      bin_f_d = temp_f;
      bcd_c_d = '0;
      bcd_f_d = '0;
      step_d  = '0;
    end
  end

  // Stage 0: map the raster address onto a character cell and glyph pixel
  always_comb begin
    int unsigned row_i, col_i, left;
    logic        in_row;
    row_i       = 32'(pix_q[10:6]);
    col_i       = 32'(pix_q[5:0]);
    left        = 0;
    in_row      = (row_i >= Y0) && (row_i < Y0 + CELL_H);
    glyph_row   = 3'((row_i - Y0) >> 1);
    cell_inside = 1'b0;
    cell_gx     = '0;
    code_up     = GLYPH_BLANK;
    code_lo     = GLYPH_BLANK;
    for (int unsigned k = 0; k < CELL_N; k++) begin
      left = X0 + k * CELL_PITCH;
      if (in_row && (col_i >= left) && (col_i < left + CELL_W)) begin
        cell_inside = 1'b1;
        cell_gx     = 3'((col_i - left) >> 1);
        code_up     = cell_glyph(bcd_c_q, k, GLYPH_C);
        code_lo     = cell_glyph(bcd_f_q, k, GLYPH_F);
      end
    end
  end

  font_5x7 u_font_up (
    .clk  (clk),
    .code (code_up),
    .row  (glyph_row),
    .bits (font_up)
  );

  font_5x7 u_font_lo (
    .clk  (clk),
    .code (code_lo),
    .row  (glyph_row),
    .bits (font_lo)
  );

  // Stage 1 follows the ROM read; stage 2 is the colour mux into the outputs
  always_comb begin
    s1_valid_d  = (state_q == RASTER);
    s1_addr_d   = pix_q;
    s1_inside_d = cell_inside;
    s1_gx_d     = cell_gx;
    wr_en_d     = s1_valid_q;
    wr_addr_d   = s1_addr_q;
    wr_data_d   = '0;
    if (s1_valid_q) begin
      wr_data_d[23:12] = (s1_inside_q && font_up[3'd4 - s1_gx_q]) ? FG_UP : BG;
      wr_data_d[11:0]  = (s1_inside_q && font_lo[3'd4 - s1_gx_q]) ? FG_LO : BG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      bin_c_q     <= '0;
      bin_f_q     <= '0;
      bcd_c_q     <= '0;
      bcd_f_q     <= '0;
      step_q      <= '0;
      pix_q       <= '0;
      flush_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_inside_q <= 1'b0;
      s1_gx_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      bin_c_q     <= bin_c_d;
      bin_f_q     <= bin_f_d;
      bcd_c_q     <= bcd_c_d;
      bcd_f_q     <= bcd_f_d;
      step_q      <= step_d;
      pix_q       <= pix_d;
      flush_q     <= flush_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_inside_q <= s1_inside_d;
      s1_gx_q     <= s1_gx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = {1'b0, wr_addr_q};
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule
